sd_line_responder: RTL and testbench

Cache-facing line port of the SD path. Accepts 128-bit line read/write requests from the cache's SD-side handshake and performs them as a single command beat followed by 32-bit word bursts on the SD controller's word port. For reads, it reassembles the returned words into a line and hands the line back to the cache. It sits between the cache and the SD card controller and replaces the ad-hoc line responder used in simulation.

---
 rtl/sd_line_pkg.sv | 24 ++
 rtl/sd_line_gearbox.sv | 45 ++++
 rtl/sd_line_responder.sv | 139 +++++++++++++
 tb/tb_sd_line_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_line_pkg.sv
// Shared types and constants for the SD line responder.
package sd_line_pkg;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int CMD_W  = 1;
   localparam int LINE_W = 128;

   localparam int BEATS  = LINE_W / WORD_W;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int OFFS   = $clog2(LINE_W / 8);

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WSEND,
      ST_RRECV,
      ST_RESP
   } state_e;

endpackage

// File: rtl/sd_line_gearbox.sv
// Line register with word select / insert by beat index. The write path
// loads a full line and reads words out; the read path inserts words.
import sd_line_pkg::*;

module sd_line_gearbox #(
   parameter int WIDTH     = LINE_W,
   parameter int DATA      = WORD_W,
   parameter int BEAT_BITS = BEAT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  logic [WIDTH-1:0]     load_line_i,
   input  logic                 ins_i,
   input  logic [DATA-1:0]      ins_word_i,
   input  logic [BEAT_BITS-1:0] beat_i,
   output logic [WIDTH-1:0]     line_o,
   output logic [DATA-1:0]      word_o
);

   logic [WIDTH-1:0] line_q, line_d;

   // Next line value: full load wins over a single-word insert.
   always_comb begin
      line_d = line_q;
      if (load_i) begin
         line_d = load_line_i;
      end else if (ins_i) begin
         line_d[DATA*int'(beat_i) +: DATA] = ins_word_i;
      end
   end

   // Line storage register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line_o = line_q;
   assign word_o = line_q[DATA*int'(beat_i) +: DATA];

endmodule

// File: rtl/sd_line_responder.sv
// Cache-facing line port of the SD path: one command beat, then a burst of
// words to or from the SD controller. All valid/ready outputs decode from
// state only, data/address outputs come from registers.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a raised valid keeps its payload stable until that edge.
import sd_line_pkg::*;

module sd_line_responder #(
   parameter int ADDR  = ADDR_W,
   parameter int DATA  = WORD_W,
   parameter int CMD   = CMD_W,
   parameter int WIDTH = LINE_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             line_valid_in,
   output logic             line_ready_in,
   input  logic [ADDR-1:0]  line_addr_in,
   input  logic [WIDTH-1:0] line_data_in,
   input  logic [CMD-1:0]   line_cmd_in,
   output logic             line_valid_out,
   input  logic             line_ready_out,
   output logic [WIDTH-1:0] line_data_out,
   output logic             blk_valid_out,
   input  logic             blk_ready_out,
   output logic [ADDR-1:0]  blk_addr_out,
   output logic [CMD-1:0]   blk_cmd_out,
   output logic             wd_valid_out,
   input  logic             wd_ready_out,
   output logic [DATA-1:0]  wd_data_out,
   input  logic             rd_valid_in,
   output logic             rd_ready_in,
   input  logic [DATA-1:0]  rd_data_in,
   output state_e           dbg_state_o
);

   localparam int N_BEATS = WIDTH / DATA;
   localparam int NB_W    = $clog2(N_BEATS);
   localparam int N_OFFS  = $clog2(WIDTH / 8);

   state_e          state_q, state_d;
   logic [NB_W-1:0] beat_q, beat_d;
   logic [ADDR-1:0] addr_q, addr_d;
   logic [CMD-1:0]  cmd_q, cmd_d;
   logic            load, ins;
   logic            last_beat;

   assign last_beat = (beat_q == NB_W'(N_BEATS - 1));

   // Next-state, handshake decode and gearbox control.
   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      addr_d         = addr_q;
      cmd_d          = cmd_q;
      load           = 1'b0;
      ins            = 1'b0;
      line_ready_in  = 1'b0;
      blk_valid_out  = 1'b0;
      wd_valid_out   = 1'b0;
      rd_ready_in    = 1'b0;
      line_valid_out = 1'b0;
      case (state_q)
         ST_IDLE: begin
            line_ready_in = 1'b1;
            if (line_valid_in) begin
               addr_d  = {line_addr_in[ADDR-1:N_OFFS], {N_OFFS{1'b0}}};
               cmd_d   = line_cmd_in;
               load    = 1'b1;
               beat_d  = '0;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            blk_valid_out = 1'b1;
            if (blk_ready_out) begin
               state_d = (cmd_q[0] == CMD_WRITE) ? ST_WSEND : ST_RRECV;
            end
         end
         ST_WSEND: begin
            wd_valid_out = 1'b1;
            if (wd_ready_out) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = ST_IDLE;
            end
         end
         ST_RRECV: begin
            rd_ready_in = 1'b1;
            if (rd_valid_in) begin
               ins    = 1'b1;
               beat_d = beat_q + 1'b1;
               if (last_beat) state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            line_valid_out = 1'b1;
            if (line_ready_out) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, beat counter and latched request registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
      end
   end

   sd_line_gearbox #(
      .WIDTH     (WIDTH),
      .DATA      (DATA),
      .BEAT_BITS (NB_W)
   ) u_gearbox (
      .clk_i       (clock),
      .rst_ni      (reset),
      .load_i      (load),
      .load_line_i (line_data_in),
      .ins_i       (ins),
      .ins_word_i  (rd_data_in),
      .beat_i      (beat_q),
      .line_o      (line_data_out),
      .word_o      (wd_data_out)
   );

   assign blk_addr_out = addr_q;
   assign blk_cmd_out  = cmd_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sd_line_responder.sv
// Bench for sd_line_responder: directed scenarios plus randomized traffic,
// with an SD-controller memory model and a line-level reference.
module tb_sd_line_responder;
   import sd_line_pkg::*;

   localparam int BUDGET = 200;

   logic         clock = 1'b0;
   logic         reset;
   logic         line_valid_in;
   logic         line_ready_in;
   logic [31:0]  line_addr_in;
   logic [127:0] line_data_in;
   logic [0:0]   line_cmd_in;
   logic         line_valid_out;
   logic         line_ready_out;
   logic [127:0] line_data_out;
   logic         blk_valid_out;
   logic         blk_ready_out;
   logic [31:0]  blk_addr_out;
   logic [0:0]   blk_cmd_out;
   logic         wd_valid_out;
   logic         wd_ready_out;
   logic [31:0]  wd_data_out;
   logic         rd_valid_in;
   logic         rd_ready_in;
   logic [31:0]  rd_data_in;
   state_e       dbg_state;

   sd_line_responder dut (
      .clock          (clock),
      .reset          (reset),
      .line_valid_in  (line_valid_in),
      .line_ready_in  (line_ready_in),
      .line_addr_in   (line_addr_in),
      .line_data_in   (line_data_in),
      .line_cmd_in    (line_cmd_in),
      .line_valid_out (line_valid_out),
      .line_ready_out (line_ready_out),
      .line_data_out  (line_data_out),
      .blk_valid_out  (blk_valid_out),
      .blk_ready_out  (blk_ready_out),
      .blk_addr_out   (blk_addr_out),
      .blk_cmd_out    (blk_cmd_out),
      .wd_valid_out   (wd_valid_out),
      .wd_ready_out   (wd_ready_out),
      .wd_data_out    (wd_data_out),
      .rd_valid_in    (rd_valid_in),
      .rd_ready_in    (rd_ready_in),
      .rd_data_in     (rd_data_in),
      .dbg_state_o    (dbg_state)
   );

   // clock / cycle counter
   always #5 clock = ~clock;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   bit tog = 1'b0;

   // SD-controller backing store, keyed by line-aligned address
   logic [127:0] mem [logic [31:0]];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] model_line(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = rand_line();
      return mem[a];
   endfunction

   // mode 0: always ready, 1: alternate, 2: random
   function automatic logic pick_ready(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) begin
         tog = ~tog;
         return tog;
      end
      return 1'($urandom_range(0, 1));
   endfunction

   // One full request; called at a negedge, returns at a negedge.
   // abort_at >= 0 stops a read after that many words have been delivered.
   task automatic run_req(input bit is_wr, input logic [31:0] addr, input logic [127:0] wline,
                          input int mode, input int hold, input int abort_at);
      logic [31:0]  al;
      logic [127:0] rline;
      int           n, k, acc;
      bit           done, xfer;
      al    = addr & 32'hFFFF_FFF0;
      rline = '0;
      if (is_wr) mem[al] = wline;
      else       rline   = model_line(al);

      // request
      line_valid_in = 1'b1;
      line_addr_in  = addr;
      line_data_in  = wline;
      line_cmd_in   = is_wr;
      n = 0;
      while (!line_ready_in && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      if (n >= BUDGET) begin
         check("accept_timeout", 1, 0);
         line_valid_in = 1'b0;
         return;
      end
      @(negedge clock);
      acc           = cyc;
      line_valid_in = 1'b0;
      line_addr_in  = $urandom;
      line_data_in  = rand_line();
      check("busy_ready", line_ready_in, 0);

      // command beat; a read pre-raises its first word to show it waits
      if (!is_wr) begin
         rd_valid_in = 1'b1;
         rd_data_in  = rline[31:0];
      end
      done = 1'b0;
      n    = 0;
      while (!done && n < BUDGET) begin
         check("rd_ready_in_cmd", rd_ready_in, 0);
         if (blk_valid_out) begin
            check("blk_addr", blk_addr_out, al);
            check("blk_cmd", blk_cmd_out, is_wr);
            blk_ready_out = pick_ready(mode);
            done          = blk_ready_out;
         end else begin
            blk_ready_out = 1'b0;
         end
         @(negedge clock);
         n++;
      end
      blk_ready_out = 1'b0;
      if (!done) begin
         check("cmd_timeout", 1, 0);
         return;
      end

      if (is_wr) begin
         k = 0;
         n = 0;
         while (k < 4 && n < BUDGET) begin
            if (wd_valid_out) begin
               check($sformatf("wd_word%0d", k), wd_data_out, wline[32*k +: 32]);
               wd_ready_out = pick_ready(mode);
               if (wd_ready_out) k++;
            end else begin
               wd_ready_out = 1'b0;
            end
            @(negedge clock);
            n++;
         end
         wd_ready_out = 1'b0;
         if (k < 4) begin
            check("wd_timeout", 1, 0);
            return;
         end
         check("wr_done_valid", wd_valid_out, 0);
         check("wr_done_ready", line_ready_in, 1);
         if (mode == 0) check("wr_latency", cyc - acc, 5);
      end else begin
         k = 0;
         n = 0;
         while (k < 4 && n < BUDGET) begin
            if (k == abort_at) begin
               rd_valid_in = 1'b0;
               return;
            end
            if (!rd_valid_in && pick_ready(mode)) begin
               rd_valid_in = 1'b1;
               rd_data_in  = rline[32*k +: 32];
            end
            xfer = rd_valid_in && rd_ready_in;
            @(negedge clock);
            n++;
            if (xfer) begin
               k++;
               rd_valid_in = 1'b0;
               rd_data_in  = $urandom;
            end
         end
         rd_valid_in = 1'b0;
         n = 0;
         while (!line_valid_out && n < BUDGET) begin
            @(negedge clock);
            n++;
         end
         if (n >= BUDGET) begin
            check("resp_timeout", 1, 0);
            return;
         end
         if (mode == 0) check("rd_latency", cyc - acc, 5);
         for (int h = 0; h < hold; h++) begin
            line_ready_out = 1'b0;
            check("resp_valid_hold", line_valid_out, 1);
            check("resp_data_hold", line_data_out, rline);
            check("resp_busy_ready", line_ready_in, 0);
            @(negedge clock);
         end
         check("resp_data", line_data_out, rline);
         line_ready_out = 1'b1;
         @(negedge clock);
         line_ready_out = 1'b0;
         check("resp_done_valid", line_valid_out, 0);
         check("resp_done_ready", line_ready_in, 1);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_line_ready_in"}, line_ready_in, 1);
      check({tag, "_line_valid_out"}, line_valid_out, 0);
      check({tag, "_blk_valid"}, blk_valid_out, 0);
      check({tag, "_wd_valid"}, wd_valid_out, 0);
      check({tag, "_rd_ready"}, rd_ready_in, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   // watchdog
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   logic [127:0] wr_line;
   logic [127:0] b2b_lines [8];

   initial begin
      reset          = 1'b0;
      line_valid_in  = 1'b0;
      line_addr_in   = '0;
      line_data_in   = '0;
      line_cmd_in    = '0;
      line_ready_out = 1'b0;
      blk_ready_out  = 1'b0;
      wd_ready_out   = 1'b0;
      rd_valid_in    = 1'b0;
      rd_data_in     = '0;
      repeat (3) @(negedge clock);

      // reset state
      check_idle_outputs("reset");
      check("reset_blk_addr", blk_addr_out, 0);
      check("reset_blk_cmd", blk_cmd_out, 0);
      check("reset_line_data", line_data_out, 0);
      check("reset_wd_data", wd_data_out, 0);
      reset = 1'b1;
      @(negedge clock);

      // unaligned read with fixed controller words
      mem[32'h0000_1230] = 128'h44444444_33333333_22222222_11111111;
      run_req(1'b0, 32'h0000_1237, rand_line(), 0, 0, -1);

      // write, no stalls, then with alternating write-word stalls
      wr_line = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
      run_req(1'b1, 32'h0000_0040, wr_line, 0, 0, -1);
      run_req(1'b1, 32'h0000_0040, wr_line, 1, 0, -1);

      // read back with the cache holding off for 10 cycles
      run_req(1'b0, 32'h0000_0040, rand_line(), 0, 10, -1);

      // reset in the middle of a read after two words
      run_req(1'b0, 32'h0000_0080, rand_line(), 0, 0, 2);
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset");
      check("midreset_line_data", line_data_out, 0);
      check("midreset_blk_addr", blk_addr_out, 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_req(1'b1, 32'h0000_0080, rand_line(), 0, 0, -1);
      run_req(1'b0, 32'h0000_0080, rand_line(), 2, 2, -1);

      // back-to-back: 8 writes then 8 reads of the same lines
      for (int i = 0; i < 8; i++) begin
         b2b_lines[i] = rand_line();
         run_req(1'b1, 32'(i) << 4, b2b_lines[i], $urandom_range(0, 2), 0, -1);
      end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("b2b_model%0d", i), mem[32'(i) << 4], b2b_lines[i]);
         run_req(1'b0, 32'(i) << 4, rand_line(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end

      // randomized mix over a small address window
      for (int i = 0; i < 30; i++) begin
         run_req(1'($urandom_range(0, 1)), $urandom_range(0, 255), rand_line(),
                 $urandom_range(0, 2), $urandom_range(0, 4), -1);
      end

      repeat (2) @(negedge clock);
      check_idle_outputs("final");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
